// File: rtl/clock_mode_ctrl.sv
// clock_mode_ctrl: key-driven mode sequencer for the multi-function digital clock.
// Turns debounced mode/turn/change pulses into mode, edit field, strobes, alarm/stopwatch state and blink.
module clock_mode_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 500_000_000,
  parameter int unsigned BLINK_HALF     = 12_500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] key_pulse,
  output logic [1:0] mode_state,
  output logic [1:0] field_sel,
  output logic       inc_time,
  output logic       inc_alarm,
  output logic       time_hold,
  output logic       alarm_en,
  output logic       sw_run,
  output logic       sw_clear,
  output logic       blink_on
);

  localparam int unsigned IDLE_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned BLINK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [IDLE_W-1:0]  IDLE_LAST  = IDLE_W'(TIMEOUT_CYCLES - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);

  typedef enum logic [1:0] {
    MODE_NORMAL    = 2'd0,
    MODE_SET_TIME  = 2'd1,
    MODE_SET_ALARM = 2'd2,
    MODE_STOPWATCH = 2'd3
  } mode_e;

  localparam logic [1:0] FIELD_HOUR  = 2'd0;
  localparam logic [1:0] FIELD_MIN   = 2'd1;
  localparam logic [1:0] FIELD_SEC   = 2'd2;
  localparam logic [1:0] FIELD_ALARM = 2'd3;

  mode_e              mode_r, mode_nx_s;
  logic [1:0]         field_r, field_nx_s;
  logic [IDLE_W-1:0]  idle_cnt_r, idle_nx_s;
  logic [BLINK_W-1:0] blink_cnt_r, blink_cnt_nx_s;
  logic               blink_on_r, blink_nx_s;
  logic               alarm_en_r, alarm_en_nx_s;
  logic               sw_run_r, sw_run_nx_s;
  logic               inc_time_r, inc_time_nx_s;
  logic               inc_alarm_r, inc_alarm_nx_s;
  logic               sw_clear_r, sw_clear_nx_s;
  logic               time_hold_r, time_hold_nx_s;
  logic               mode_k_s, turn_k_s, change_k_s, any_key_s;
  logic               timeout_s, edit_nx_s;

  // Priority mode > turn > change: lower keys in the same cycle are dropped.
  assign mode_k_s   = key_pulse[0];
  assign turn_k_s   = key_pulse[1] & ~key_pulse[0];
  assign change_k_s = key_pulse[2] & ~key_pulse[1] & ~key_pulse[0];
  assign any_key_s  = |key_pulse;
  assign timeout_s  = ~any_key_s & (idle_cnt_r == IDLE_LAST);

  // State and output registers; reset aborts any edit in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_r      <= MODE_NORMAL;
      field_r     <= FIELD_HOUR;
      idle_cnt_r  <= '0;
      blink_cnt_r <= '0;
      blink_on_r  <= 1'b1;
      alarm_en_r  <= 1'b0;
      sw_run_r    <= 1'b0;
      inc_time_r  <= 1'b0;
      inc_alarm_r <= 1'b0;
      sw_clear_r  <= 1'b0;
      time_hold_r <= 1'b0;
    end else begin
      mode_r      <= mode_nx_s;
      field_r     <= field_nx_s;
      idle_cnt_r  <= idle_nx_s;
      blink_cnt_r <= blink_cnt_nx_s;
      blink_on_r  <= blink_nx_s;
      alarm_en_r  <= alarm_en_nx_s;
      sw_run_r    <= sw_run_nx_s;
      inc_time_r  <= inc_time_nx_s;
      inc_alarm_r <= inc_alarm_nx_s;
      sw_clear_r  <= sw_clear_nx_s;
      time_hold_r <= time_hold_nx_s;
    end
  end

  // Next-state logic: mode/field sequencing, alarm and stopwatch toggles, idle and blink timers.
  always_comb begin
    mode_nx_s     = mode_r;
    field_nx_s    = field_r;
    alarm_en_nx_s = alarm_en_r;
    sw_run_nx_s   = sw_run_r;
    case (mode_r)
      MODE_NORMAL: begin
        if (mode_k_s) begin
          mode_nx_s  = MODE_SET_TIME;
          field_nx_s = FIELD_HOUR;
        end else begin
          mode_nx_s  = MODE_NORMAL;
        end
      end
      MODE_SET_TIME: begin
        if (mode_k_s) begin
          mode_nx_s  = MODE_SET_ALARM;
          field_nx_s = FIELD_HOUR;
        end else if (turn_k_s) begin
          field_nx_s = (field_r >= FIELD_SEC) ? FIELD_HOUR : field_r + 2'd1;
        end else if (timeout_s) begin
          mode_nx_s  = MODE_NORMAL;
          field_nx_s = FIELD_HOUR;
        end else begin
          mode_nx_s  = MODE_SET_TIME;
        end
      end
      MODE_SET_ALARM: begin
        if (mode_k_s) begin
          mode_nx_s  = MODE_STOPWATCH;
          field_nx_s = FIELD_HOUR;
        end else if (turn_k_s) begin
          case (field_r)
            FIELD_HOUR: field_nx_s = FIELD_MIN;
            FIELD_MIN:  field_nx_s = FIELD_ALARM;
            default:    field_nx_s = FIELD_HOUR;
          endcase
        end else if (change_k_s) begin
          alarm_en_nx_s = (field_r == FIELD_ALARM) ? ~alarm_en_r : alarm_en_r;
        end else if (timeout_s) begin
          mode_nx_s  = MODE_NORMAL;
          field_nx_s = FIELD_HOUR;
        end else begin
          mode_nx_s  = MODE_SET_ALARM;
        end
      end
      MODE_STOPWATCH: begin
        if (mode_k_s) begin
          mode_nx_s  = MODE_NORMAL;
          field_nx_s = FIELD_HOUR;
        end else if (change_k_s) begin
          sw_run_nx_s = ~sw_run_r;
        end else begin
          mode_nx_s  = MODE_STOPWATCH;
        end
      end
      default: begin
        mode_nx_s  = MODE_NORMAL;
        field_nx_s = FIELD_HOUR;
      end
    endcase

    edit_nx_s = (mode_nx_s == MODE_SET_TIME) || (mode_nx_s == MODE_SET_ALARM);

    // Timers only run while editing; every key restarts both.
    if (!edit_nx_s || any_key_s) begin
      idle_nx_s = '0;
    end else if (idle_cnt_r == IDLE_LAST) begin
      idle_nx_s = idle_cnt_r;
    end else begin
      idle_nx_s = idle_cnt_r + IDLE_W'(1);
    end

    if (!edit_nx_s || any_key_s) begin
      blink_cnt_nx_s = '0;
      blink_nx_s     = 1'b1;
    end else if (blink_cnt_r == BLINK_LAST) begin
      blink_cnt_nx_s = '0;
      blink_nx_s     = ~blink_on_r;
    end else begin
      blink_cnt_nx_s = blink_cnt_r + BLINK_W'(1);
      blink_nx_s     = blink_on_r;
    end
  end

  // Output logic: one-cycle strobes and the time-freeze flag, registered above.
  always_comb begin
    inc_time_nx_s  = change_k_s & (mode_r == MODE_SET_TIME);
    inc_alarm_nx_s = change_k_s & (mode_r == MODE_SET_ALARM) & (field_r != FIELD_ALARM);
    sw_clear_nx_s  = turn_k_s & (mode_r == MODE_STOPWATCH) & ~sw_run_r;
    time_hold_nx_s = (mode_nx_s == MODE_SET_TIME);
  end

  assign mode_state = mode_r;
  assign field_sel  = field_r;
  assign inc_time   = inc_time_r;
  assign inc_alarm  = inc_alarm_r;
  assign time_hold  = time_hold_r;
  assign alarm_en   = alarm_en_r;
  assign sw_run     = sw_run_r;
  assign sw_clear   = sw_clear_r;
  assign blink_on   = blink_on_r;

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// tb_clock_mode_ctrl: directed self-checking bench for clock_mode_ctrl.
// Short timeout/blink parameters keep the idle-return and blink scenarios brief.
module tb_clock_mode_ctrl;

  logic       clk;
  logic       rst;
  logic [2:0] key_pulse;
  logic [1:0] mode_state;
  logic [1:0] field_sel;
  logic       inc_time, inc_alarm, time_hold, alarm_en, sw_run, sw_clear, blink_on;

  int errors = 0;
  int checks = 0;

  localparam logic [2:0] K_MODE   = 3'b001;
  localparam logic [2:0] K_TURN   = 3'b010;
  localparam logic [2:0] K_CHANGE = 3'b100;

  clock_mode_ctrl #(.TIMEOUT_CYCLES(100), .BLINK_HALF(8)) dut (
    .clk(clk), .rst(rst), .key_pulse(key_pulse),
    .mode_state(mode_state), .field_sel(field_sel),
    .inc_time(inc_time), .inc_alarm(inc_alarm), .time_hold(time_hold),
    .alarm_en(alarm_en), .sw_run(sw_run), .sw_clear(sw_clear), .blink_on(blink_on)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one key pulse at the current falling edge; returns one falling edge later.
  task automatic press(input logic [2:0] k);
    key_pulse = k;
    @(negedge clk);
    key_pulse = 3'b000;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (mode_state !== 2'd0) begin errors++; $display("FAIL rst_mode got=%0d exp=0", mode_state); end
    checks++; if (field_sel !== 2'd0) begin errors++; $display("FAIL rst_field got=%0d exp=0", field_sel); end
    checks++; if ({inc_time, inc_alarm, sw_clear, time_hold, alarm_en, sw_run} !== 6'b000000) begin
      errors++; $display("FAIL rst_flags got=%b exp=000000", {inc_time, inc_alarm, sw_clear, time_hold, alarm_en, sw_run}); end
    checks++; if (blink_on !== 1'b1) begin errors++; $display("FAIL rst_blink got=%b exp=1", blink_on); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (mode_state !== 2'd0) begin errors++; $display("FAIL rst_rel_mode got=%0d exp=0", mode_state); end
  endtask

  task automatic test_mode_cycle();
    logic [1:0] exp_m;
    for (int i = 0; i < 4; i++) begin
      exp_m = 2'(i + 1);
      press(K_MODE);
      checks++; if (mode_state !== exp_m) begin errors++; $display("FAIL cyc_mode%0d got=%0d exp=%0d", i, mode_state, exp_m); end
      checks++; if (field_sel !== 2'd0) begin errors++; $display("FAIL cyc_field%0d got=%0d exp=0", i, field_sel); end
      checks++; if (time_hold !== (exp_m == 2'd1)) begin errors++; $display("FAIL cyc_hold%0d got=%b exp=%b", i, time_hold, exp_m == 2'd1); end
      repeat (9) @(negedge clk);
      checks++; if (mode_state !== exp_m) begin errors++; $display("FAIL cyc_stay%0d got=%0d exp=%0d", i, mode_state, exp_m); end
    end
  endtask

  task automatic test_set_time();
    press(K_TURN);
    checks++; if (field_sel !== 2'd0) begin errors++; $display("FAIL norm_turn field got=%0d exp=0", field_sel); end
    press(K_CHANGE);
    checks++; if (inc_time !== 1'b0) begin errors++; $display("FAIL norm_change inc_time got=%b exp=0", inc_time); end
    press(K_MODE);
    press(K_TURN);
    checks++; if (field_sel !== 2'd1) begin errors++; $display("FAIL st_turn1 got=%0d exp=1", field_sel); end
    press(K_TURN);
    checks++; if (field_sel !== 2'd2) begin errors++; $display("FAIL st_turn2 got=%0d exp=2", field_sel); end
    press(K_CHANGE);
    checks++; if (inc_time !== 1'b1 || field_sel !== 2'd2) begin
      errors++; $display("FAIL st_inc got inc_time=%b field=%0d exp 1/2", inc_time, field_sel); end
    checks++; if (inc_alarm !== 1'b0) begin errors++; $display("FAIL st_no_inc_alarm got=%b exp=0", inc_alarm); end
    @(negedge clk);
    checks++; if (inc_time !== 1'b0) begin errors++; $display("FAIL st_inc_single got=%b exp=0", inc_time); end
    press(K_TURN);
    checks++; if (field_sel !== 2'd0) begin errors++; $display("FAIL st_turn_wrap got=%0d exp=0", field_sel); end
  endtask

  task automatic test_back_to_back();
    key_pulse = K_CHANGE;
    @(negedge clk);
    checks++; if (inc_time !== 1'b1) begin errors++; $display("FAIL b2b_first got=%b exp=1", inc_time); end
    @(negedge clk);
    key_pulse = 3'b000;
    checks++; if (inc_time !== 1'b1) begin errors++; $display("FAIL b2b_second got=%b exp=1", inc_time); end
    @(negedge clk);
    checks++; if (inc_time !== 1'b0) begin errors++; $display("FAIL b2b_end got=%b exp=0", inc_time); end
    press(K_MODE);
  endtask

  task automatic test_set_alarm();
    checks++; if (mode_state !== 2'd2 || time_hold !== 1'b0) begin
      errors++; $display("FAIL sa_enter got mode=%0d hold=%b exp 2/0", mode_state, time_hold); end
    press(K_CHANGE);
    checks++; if (inc_alarm !== 1'b1 || inc_time !== 1'b0 || alarm_en !== 1'b0) begin
      errors++; $display("FAIL sa_inc got inc_alarm=%b inc_time=%b alarm_en=%b exp 1/0/0", inc_alarm, inc_time, alarm_en); end
    press(K_TURN);
    checks++; if (field_sel !== 2'd1) begin errors++; $display("FAIL sa_turn1 got=%0d exp=1", field_sel); end
    press(K_TURN);
    checks++; if (field_sel !== 2'd3) begin errors++; $display("FAIL sa_turn2 got=%0d exp=3", field_sel); end
    press(K_CHANGE);
    checks++; if (alarm_en !== 1'b1 || inc_alarm !== 1'b0) begin
      errors++; $display("FAIL sa_arm got alarm_en=%b inc_alarm=%b exp 1/0", alarm_en, inc_alarm); end
    press(K_CHANGE);
    checks++; if (alarm_en !== 1'b0) begin errors++; $display("FAIL sa_disarm got=%b exp=0", alarm_en); end
    press(K_CHANGE);
    press(K_MODE | K_CHANGE);
    checks++; if (mode_state !== 2'd3 || alarm_en !== 1'b1 || field_sel !== 2'd0) begin
      errors++; $display("FAIL sa_prio got mode=%0d alarm_en=%b field=%0d exp 3/1/0", mode_state, alarm_en, field_sel); end
  endtask

  task automatic test_stopwatch();
    press(K_CHANGE);
    checks++; if (sw_run !== 1'b1) begin errors++; $display("FAIL sw_start got=%b exp=1", sw_run); end
    press(K_TURN);
    checks++; if (sw_clear !== 1'b0 || sw_run !== 1'b1) begin
      errors++; $display("FAIL sw_clear_running got clear=%b run=%b exp 0/1", sw_clear, sw_run); end
    press(K_CHANGE);
    checks++; if (sw_run !== 1'b0) begin errors++; $display("FAIL sw_stop got=%b exp=0", sw_run); end
    press(K_TURN | K_CHANGE);
    checks++; if (sw_clear !== 1'b1 || sw_run !== 1'b0) begin
      errors++; $display("FAIL sw_prio got clear=%b run=%b exp 1/0", sw_clear, sw_run); end
    @(negedge clk);
    checks++; if (sw_clear !== 1'b0) begin errors++; $display("FAIL sw_clear_single got=%b exp=0", sw_clear); end
    press(K_TURN);
    checks++; if (sw_clear !== 1'b1) begin errors++; $display("FAIL sw_clear got=%b exp=1", sw_clear); end
    press(K_CHANGE);
    press(K_MODE);
    checks++; if (mode_state !== 2'd0 || sw_run !== 1'b1 || alarm_en !== 1'b1) begin
      errors++; $display("FAIL sw_background got mode=%0d run=%b alarm_en=%b exp 0/1/1", mode_state, sw_run, alarm_en); end
  endtask

  task automatic test_timeout_blink();
    press(K_MODE);
    press(K_TURN);
    checks++; if (blink_on !== 1'b1) begin errors++; $display("FAIL bl_c0 got=%b exp=1", blink_on); end
    repeat (7) @(negedge clk);
    checks++; if (blink_on !== 1'b1) begin errors++; $display("FAIL bl_c7 got=%b exp=1", blink_on); end
    @(negedge clk);
    checks++; if (blink_on !== 1'b0) begin errors++; $display("FAIL bl_c8 got=%b exp=0", blink_on); end
    repeat (8) @(negedge clk);
    checks++; if (blink_on !== 1'b1) begin errors++; $display("FAIL bl_c16 got=%b exp=1", blink_on); end
    repeat (83) @(negedge clk);
    checks++; if (mode_state !== 2'd1 || time_hold !== 1'b1 || field_sel !== 2'd1) begin
      errors++; $display("FAIL to_c99 got mode=%0d hold=%b field=%0d exp 1/1/1", mode_state, time_hold, field_sel); end
    @(negedge clk);
    checks++; if (mode_state !== 2'd0 || time_hold !== 1'b0 || field_sel !== 2'd0 || blink_on !== 1'b1) begin
      errors++; $display("FAIL to_c100 got mode=%0d hold=%b field=%0d blink=%b exp 0/0/0/1", mode_state, time_hold, field_sel, blink_on); end
    press(K_MODE);
    repeat (99) @(negedge clk);
    checks++; if (mode_state !== 2'd1) begin errors++; $display("FAIL to_pre got=%0d exp=1", mode_state); end
    press(K_TURN);
    checks++; if (mode_state !== 2'd1 || field_sel !== 2'd1 || blink_on !== 1'b1) begin
      errors++; $display("FAIL to_keywins got mode=%0d field=%0d blink=%b exp 1/1/1", mode_state, field_sel, blink_on); end
    repeat (11) @(negedge clk);
    checks++; if (blink_on !== 1'b0) begin errors++; $display("FAIL bl_pre_key got=%b exp=0", blink_on); end
    press(K_CHANGE);
    checks++; if (blink_on !== 1'b1 || inc_time !== 1'b1) begin
      errors++; $display("FAIL bl_forced got blink=%b inc_time=%b exp 1/1", blink_on, inc_time); end
    repeat (99) @(negedge clk);
    checks++; if (mode_state !== 2'd1) begin errors++; $display("FAIL to2_pre got=%0d exp=1", mode_state); end
    @(negedge clk);
    checks++; if (mode_state !== 2'd0) begin errors++; $display("FAIL to2_exp got=%0d exp=0", mode_state); end
  endtask

  task automatic test_reset_mid();
    press(K_MODE);
    press(K_MODE);
    press(K_TURN);
    checks++; if (mode_state !== 2'd2 || alarm_en !== 1'b1 || sw_run !== 1'b1 || field_sel !== 2'd1) begin
      errors++; $display("FAIL rm_pre got mode=%0d alarm_en=%b run=%b field=%0d exp 2/1/1/1", mode_state, alarm_en, sw_run, field_sel); end
    #2 rst = 1'b1;
    #1;
    checks++; if (mode_state !== 2'd0 || field_sel !== 2'd0 || alarm_en !== 1'b0 || sw_run !== 1'b0) begin
      errors++; $display("FAIL rm_async got mode=%0d field=%0d alarm_en=%b run=%b exp 0/0/0/0", mode_state, field_sel, alarm_en, sw_run); end
    checks++; if (blink_on !== 1'b1 || time_hold !== 1'b0 || {inc_time, inc_alarm, sw_clear} !== 3'b000) begin
      errors++; $display("FAIL rm_async_misc got blink=%b hold=%b strobes=%b exp 1/0/000", blink_on, time_hold, {inc_time, inc_alarm, sw_clear}); end
    @(negedge clk);
    rst = 1'b0;
    press(K_TURN);
    checks++; if (mode_state !== 2'd0 || field_sel !== 2'd0) begin
      errors++; $display("FAIL rm_turn got mode=%0d field=%0d exp 0/0", mode_state, field_sel); end
    press(K_MODE);
    checks++; if (mode_state !== 2'd1 || time_hold !== 1'b1) begin
      errors++; $display("FAIL rm_first got mode=%0d hold=%b exp 1/1", mode_state, time_hold); end
  endtask

  initial begin
    rst = 1'b1;
    key_pulse = 3'b000;
    test_reset();
    test_mode_cycle();
    test_set_time();
    test_back_to_back();
    test_set_alarm();
    test_stopwatch();
    test_timeout_blink();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
